// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// instruction size and the alignment mask for redirect targets.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // Low address bits that are forced to zero on every redirect target
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_seq_sat_counter.sv
// Saturating event counter with synchronous clear, used for branch statistics.
// Only compiled when BRANCH_STATS_EN is defined.
`ifdef BRANCH_STATS_EN
module pc_seq_sat_counter #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              i_clear,
  input  logic              i_inc,
  output logic [STAT_W-1:0] o_cnt
);

  logic [STAT_W-1:0] r_cnt;

  // Hold at all-ones once reached
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {STAT_W{1'b1}})) begin
      r_cnt <= r_cnt + STAT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Program counter / fetch request owner: arbitrates redirect, stall and imem backpressure.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned     STAT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              br_resolve_i,
  input  logic              pc_sel_i,
  input  logic              jump_i,
  input  logic [XLEN-1:0]   target_i,
  input  logic              imem_ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic              pc_valid_o,
  output logic              redirect_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] taken_cnt_o
`endif
);

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;

  logic            w_take;
  logic            w_redirect;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_pc_inc;

  assign w_take     = (br_resolve_i & pc_sel_i) | jump_i;
  assign w_tgt      = target_i & ~XLEN'(ALIGN_MASK);
  assign w_pc_inc   = r_pc + XLEN'(INSTR_BYTES);
  assign w_redirect = w_take & (r_state != BOOT);

  // Redirect beats stall; FLUSH is left only on the first accepted fetch of the target
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= FETCH;
          r_pc_valid <= 1'b1;
        end
        FETCH: begin
          if (w_take) begin
            r_pc    <= w_tgt;
            r_state <= FLUSH;
          end else if (!stall_i && imem_ready_i) begin
            r_pc <= w_pc_inc;
          end
        end
        FLUSH: begin
          if (w_take) begin
            r_pc <= w_tgt;
          end else if (imem_ready_i && !stall_i) begin
            r_pc    <= w_pc_inc;
            r_state <= FETCH;
          end
        end
        default: begin
          r_state    <= BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o          = r_pc;
  assign pc_valid_o    = r_pc_valid;
  assign redirect_o    = w_redirect;
  assign flush_id_ex_o = w_redirect;
  assign flush_if_id_o = w_redirect | (r_state == FLUSH);

`ifdef BRANCH_STATS_EN
  logic w_stats_en;

  assign w_stats_en = (r_state != BOOT);

  pc_seq_sat_counter #(
    .STAT_W (STAT_W)
  ) u_branch_cnt (
    .clk     (clk),
    .i_clear (reset),
    .i_inc   (w_stats_en & br_resolve_i),
    .o_cnt   (branch_cnt_o)
  );

  pc_seq_sat_counter #(
    .STAT_W (STAT_W)
  ) u_taken_cnt (
    .clk     (clk),
    .i_clear (reset),
    .i_inc   (w_stats_en & br_resolve_i & pc_sel_i),
    .o_cnt   (taken_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// against a behavioural model; two instances (RESET_PC 0 and 32'hFFFF_FFFC).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic        sel = 1'b0;
  logic        jmp = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] tgt = 32'h0;

  logic [31:0] o_pc   [2];
  logic        o_val  [2];
  logic        o_red  [2];
  logic        o_fif  [2];
  logic        o_fie  [2];
`ifdef BRANCH_STATS_EN
  logic [15:0] bc0, tc0;
  logic [2:0]  bc1, tc1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut0 (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .br_resolve_i  (br),
    .pc_sel_i      (sel),
    .jump_i        (jmp),
    .target_i      (tgt),
    .imem_ready_i  (rdy),
    .pc_o          (o_pc[0]),
    .pc_valid_o    (o_val[0]),
    .redirect_o    (o_red[0]),
    .flush_if_id_o (o_fif[0]),
    .flush_id_ex_o (o_fie[0])
`ifdef BRANCH_STATS_EN
    ,
    .branch_cnt_o  (bc0),
    .taken_cnt_o   (tc0)
`endif
  );

  pc_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'hFFFF_FFFC)
`ifdef BRANCH_STATS_EN
    ,
    .STAT_W   (3)
`endif
  ) dut1 (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .br_resolve_i  (br),
    .pc_sel_i      (sel),
    .jump_i        (jmp),
    .target_i      (tgt),
    .imem_ready_i  (rdy),
    .pc_o          (o_pc[1]),
    .pc_valid_o    (o_val[1]),
    .redirect_o    (o_red[1]),
    .flush_if_id_o (o_fif[1]),
    .flush_id_ex_o (o_fie[1])
`ifdef BRANCH_STATS_EN
    ,
    .branch_cnt_o  (bc1),
    .taken_cnt_o   (tc1)
`endif
  );

  // Reference model: booting flag, pending IF/ID squash, PC, saturating counters
  bit          m_boot [2] = '{1'b1, 1'b1};
  bit          m_sq   [2] = '{1'b0, 1'b0};
  logic [31:0] m_pc   [2] = '{32'h0, 32'hFFFF_FFFC};
  int          m_bc   [2] = '{0, 0};
  int          m_tc   [2] = '{0, 0};

  function automatic logic [31:0] rst_pc(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  function automatic int sat_max(input int k);
    return (k == 0) ? 65535 : 7;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_boot[k] = 1'b1;
        m_sq[k]   = 1'b0;
        m_pc[k]   = rst_pc(k);
        m_bc[k]   = 0;
        m_tc[k]   = 0;
      end else if (m_boot[k]) begin
        m_boot[k] = 1'b0;
      end else begin
        if (br && m_bc[k] < sat_max(k)) m_bc[k]++;
        if (br && sel && m_tc[k] < sat_max(k)) m_tc[k]++;
        if ((br && sel) || jmp) begin
          m_pc[k] = tgt & 32'hFFFF_FFFC;
          m_sq[k] = 1'b1;
        end else if (rdy && !stall) begin
          m_pc[k] = m_pc[k] + 32'd4;
          m_sq[k] = 1'b0;
        end
      end
    end
  end

  // Drive one cycle of inputs at the falling edge, then settle before sampling
  task automatic cyc(input logic r, input logic s, input logic b, input logic p,
                     input logic j, input logic y, input logic [31:0] t);
    @(negedge clk);
    reset = r; stall = s; br = b; sel = p; jmp = j; rdy = y; tgt = t;
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (o_pc[0] !== 32'h0) begin errors++; $display("FAIL reset_pc0 got %h want %h", o_pc[0], 32'h0); end
    checks++; if (o_pc[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc1 got %h want %h", o_pc[1], 32'hFFFF_FFFC); end
    checks++; if (o_val[0] !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_val[0]); end
    checks++; if ({o_red[0], o_fif[0], o_fie[0]} !== 3'b000) begin errors++; $display("FAIL reset_flush got %b want 000", {o_red[0], o_fif[0], o_fie[0]}); end
  endtask

  task automatic test_seq_fetch;
    logic [31:0] ep [8] = '{32'd0, 32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8, 32'd12};
    logic        ev [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        ry [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, ry[i], 32'h0);
      checks++; if (o_pc[0] !== ep[i]) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, o_pc[0], ep[i]); end
      checks++; if (o_val[0] !== ev[i]) begin errors++; $display("FAIL seq_valid[%0d] got %b want %b", i, o_val[0], ev[i]); end
    end
  endtask

  task automatic test_branch_taken;
    cyc(0, 0, 1, 1, 0, 1, 32'h43);
    checks++; if (o_pc[0] !== 32'h10) begin errors++; $display("FAIL br_pc got %h want %h", o_pc[0], 32'h10); end
    checks++; if ({o_red[0], o_fif[0], o_fie[0]} !== 3'b111) begin errors++; $display("FAIL br_flush got %b want 111", {o_red[0], o_fif[0], o_fie[0]}); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (o_pc[0] !== 32'h40) begin errors++; $display("FAIL br_tgt got %h want %h", o_pc[0], 32'h40); end
    checks++; if ({o_red[0], o_fif[0], o_fie[0]} !== 3'b010) begin errors++; $display("FAIL br_flushstate got %b want 010", {o_red[0], o_fif[0], o_fie[0]}); end
    cyc(0, 0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (o_pc[0] !== 32'h44) begin errors++; $display("FAIL br_after got %h want %h", o_pc[0], 32'h44); end
    checks++; if (o_fif[0] !== 1'b0) begin errors++; $display("FAIL br_fif_drop got %b want 0", o_fif[0]); end
  endtask

  task automatic test_not_taken;
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 1, 1, 32'h300);
    checks++; if ({o_red[0], o_fif[0], o_fie[0], o_val[0]} !== 4'b0000) begin errors++; $display("FAIL boot_take got %b want 0000", {o_red[0], o_fif[0], o_fie[0], o_val[0]}); end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 1, 0, 0, 1, 32'h55);
    checks++; if (o_pc[0] !== 32'h20) begin errors++; $display("FAIL nt_pc got %h want %h", o_pc[0], 32'h20); end
    checks++; if ({o_red[0], o_fif[0], o_fie[0]} !== 3'b000) begin errors++; $display("FAIL nt_flush got %b want 000", {o_red[0], o_fif[0], o_fie[0]}); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (o_pc[0] !== 32'h24) begin errors++; $display("FAIL nt_next got %h want %h", o_pc[0], 32'h24); end
`ifdef BRANCH_STATS_EN
    checks++; if (bc0 !== 16'd1) begin errors++; $display("FAIL nt_bcnt got %0d want 1", bc0); end
    checks++; if (tc0 !== 16'd0) begin errors++; $display("FAIL nt_tcnt got %0d want 0", tc0); end
`endif
  endtask

  task automatic test_jump_stall;
    cyc(0, 1, 0, 0, 1, 0, 32'h80);
    checks++; if ({o_red[0], o_fif[0], o_fie[0]} !== 3'b111) begin errors++; $display("FAIL js_flush got %b want 111", {o_red[0], o_fif[0], o_fie[0]}); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (o_pc[0] !== 32'h80) begin errors++; $display("FAIL js_pc got %h want %h", o_pc[0], 32'h80); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (o_fif[0] !== 1'b1) begin errors++; $display("FAIL js_fif_hold got %b want 1", o_fif[0]); end
    cyc(0, 0, 0, 0, 1, 1, 32'h103);
    checks++; if (o_red[0] !== 1'b1) begin errors++; $display("FAIL js_reredirect got %b want 1", o_red[0]); end
    cyc(0, 1, 0, 0, 0, 1, 32'h0);
    checks++; if (o_pc[0] !== 32'h100) begin errors++; $display("FAIL js_latest got %h want %h", o_pc[0], 32'h100); end
    cyc(0, 0, 0, 0, 0, 1, 32'h0);
    checks++; if ({o_pc[0], o_fif[0]} !== {32'h100, 1'b1}) begin errors++; $display("FAIL js_stallhold got %h/%b want 100/1", o_pc[0], o_fif[0]); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if ({o_pc[0], o_fif[0]} !== {32'h104, 1'b0}) begin errors++; $display("FAIL js_accept got %h/%b want 104/0", o_pc[0], o_fif[0]); end
  endtask

  task automatic test_wrap_reset;
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h0);
    checks++; if ({o_pc[1], o_val[1]} !== {32'hFFFF_FFFC, 1'b1}) begin errors++; $display("FAIL wrap_pre got %h/%b want fffffffc/1", o_pc[1], o_val[1]); end
    cyc(0, 0, 0, 0, 1, 0, 32'h200);
    checks++; if (o_pc[1] !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want %h", o_pc[1], 32'h0); end
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    checks++; if ({o_pc[1], o_fif[1]} !== {32'h200, 1'b1}) begin errors++; $display("FAIL rst_inflush got %h/%b want 200/1", o_pc[1], o_fif[1]); end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if ({o_pc[1], o_val[1], o_fif[1]} !== {32'hFFFF_FFFC, 2'b00}) begin errors++; $display("FAIL rst_abandon got %h/%b/%b want fffffffc/0/0", o_pc[1], o_val[1], o_fif[1]); end
    checks++; if ({o_pc[0], o_val[0]} !== {32'h0, 1'b0}) begin errors++; $display("FAIL rst_abandon0 got %h/%b want 0/0", o_pc[0], o_val[0]); end
  endtask

  task automatic test_random;
    logic r, s, b, p, j, y;
    logic [31:0] t;
    logic take;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = r ? 1'b0 : ($urandom_range(0, 2) == 0);
      p = $urandom_range(0, 1) == 1;
      j = r ? 1'b0 : ($urandom_range(0, 7) == 0);
      y = ($urandom_range(0, 3) != 0);
      t = $urandom;
      cyc(r, s, b, p, j, y, t);
      take = (b & p) | j;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_pc[k] !== m_pc[k] || o_val[k] !== !m_boot[k] ||
            o_red[k] !== (take & !m_boot[k]) || o_fie[k] !== (take & !m_boot[k]) ||
            o_fif[k] !== ((take & !m_boot[k]) | m_sq[k])) begin
          errors++;
          $display("FAIL rand[%0d] dut%0d got pc=%h v=%b red=%b fif=%b fie=%b want pc=%h v=%b red=%b fif=%b fie=%b",
                   i, k, o_pc[k], o_val[k], o_red[k], o_fif[k], o_fie[k], m_pc[k], !m_boot[k],
                   take & !m_boot[k], (take & !m_boot[k]) | m_sq[k], take & !m_boot[k]);
        end
      end
`ifdef BRANCH_STATS_EN
      checks++;
      if (int'(bc0) != m_bc[0] || int'(tc0) != m_tc[0] || int'(bc1) != m_bc[1] || int'(tc1) != m_tc[1]) begin
        errors++;
        $display("FAIL rand_cnt[%0d] got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                 i, bc0, tc0, bc1, tc1, m_bc[0], m_tc[0], m_bc[1], m_tc[1]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_branch_taken();
    test_not_taken();
    test_jump_stall();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
